// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the banked register file.
package regfile_pkg;

  localparam int REGFILE_NUM_REGS = 32;
  localparam int REGFILE_NUM_LONG = 4;
  localparam int REGFILE_SHORT_W  = 16;
  localparam int REGFILE_LONG_W   = 24;
  localparam int REGFILE_NUM_READ = 2;

  // Long registers occupy the top num_long indices of the file.
  function automatic logic is_long(input int idx, input int num_regs, input int num_long);
    return idx >= (num_regs - num_long);
  endfunction

endpackage

// File: rtl/banked_register_file_if.sv
// Decode/writeback-side bus of the banked register file: read ports,
// commit write and destination reservation.
interface banked_register_file_if #(
  parameter int NUM_REGS = 32,
  parameter int LONG_W   = 24,
  parameter int NUM_READ = 2
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [NUM_READ*IDX_W-1:0]  read_index;
  logic [NUM_READ*LONG_W-1:0] read_data;
  logic [NUM_READ-1:0]        read_busy;
  logic                       write_enable;
  logic [IDX_W-1:0]           write_index;
  logic [LONG_W-1:0]          write_data;
  logic                       reserve_valid;
  logic [IDX_W-1:0]           reserve_index;
  logic                       reserve_ready;

  // Core side: issues reads, writes and reservations.
  modport master (
    output read_index, write_enable, write_index, write_data,
           reserve_valid, reserve_index,
    input  read_data, read_busy, reserve_ready
  );

  // Register file side.
  modport slave (
    input  read_index, write_enable, write_index, write_data,
           reserve_valid, reserve_index,
    output read_data, read_busy, reserve_ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by accepted
// reservations and cleared by commit writes. Provides the per-read-port
// hazard lookup and the reservation handshake.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_READ*IDX_W-1:0] read_index,
  output logic [NUM_READ-1:0]       read_busy,
  input  logic                      write_enable,
  input  logic [IDX_W-1:0]          write_index,
  input  logic                      reserve_valid,
  input  logic [IDX_W-1:0]          reserve_index,
  output logic                      reserve_ready
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // A reservation is accepted when the target is free or is being freed
  // by the write committing this same cycle.
  always_comb begin
    reserve_ready = reserve_valid &&
                    (!busy[reserve_index] ||
                     (write_enable && (write_index == reserve_index)));
  end

  // Next busy vector: the write clears, an accepted reservation sets, and
  // the set is applied last so it wins on a same-index collision.
  always_comb begin
    // NOTE: busy_next takes a full default before any conditional update,
    // so every path assigns it and no latch is inferred.
    busy_next = busy;
    if (write_enable) busy_next[write_index] = 1'b0;
    if (reserve_ready) busy_next[reserve_index] = 1'b1;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // Per-port hazard lookup; a bypassing write resolves the hazard.
  always_comb begin
    read_busy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      read_busy[p] = busy[read_index[p*IDX_W +: IDX_W]] &&
                     !(write_enable && (write_index == read_index[p*IDX_W +: IDX_W]));
    end
  end

endmodule

// File: rtl/banked_register_file.sv
// Banked register file: short registers at the low indices, long registers
// at the top NUM_LONG indices, combinational read ports with write-to-read
// bypass, and a pending-write scoreboard for decode hazard detection.
module banked_register_file
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int NUM_LONG = REGFILE_NUM_LONG,
  parameter int SHORT_W  = REGFILE_SHORT_W,
  parameter int LONG_W   = REGFILE_LONG_W,
  parameter int NUM_READ = REGFILE_NUM_READ
) (
  input logic                   clk,
  input logic                   rst_n,
  banked_register_file_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // Every register viewed zero-extended to the data-bus width.
  logic [LONG_W-1:0] stored [NUM_REGS];
  logic [LONG_W-1:0] write_masked;

  // Write data as the destination will hold it: short targets keep only
  // the low SHORT_W bits.
  always_comb begin
    write_masked = LONG_W'(bus.write_data[SHORT_W-1:0]);
    if (is_long(int'(bus.write_index), NUM_REGS, NUM_LONG)) write_masked = bus.write_data;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (is_long(r, NUM_REGS, NUM_LONG)) begin : g_long
      logic [LONG_W-1:0] q;
      // Long register: stores the full bus width.
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: each entry is a discrete flop rather than a RAM array so the
        // whole file can honour the asynchronous reset; state uses <= only.
        if (!rst_n) q <= '0;
        else if (bus.write_enable && (bus.write_index == IDX_W'(r))) q <= bus.write_data;
      end
      assign stored[r] = q;
    end else begin : g_short
      logic [SHORT_W-1:0] q;
      // Short register: upper write bits are dropped.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (bus.write_enable && (bus.write_index == IDX_W'(r))) q <= bus.write_data[SHORT_W-1:0];
      end
      assign stored[r] = LONG_W'(q);
    end
  end

  // Read ports: bypass the committing write, otherwise return storage.
  always_comb begin
    bus.read_data = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      if (bus.write_enable && (bus.write_index == bus.read_index[p*IDX_W +: IDX_W]))
        bus.read_data[p*LONG_W +: LONG_W] = write_masked;
      else
        bus.read_data[p*LONG_W +: LONG_W] = stored[bus.read_index[p*IDX_W +: IDX_W]];
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_READ (NUM_READ),
    .IDX_W    (IDX_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_index    (bus.read_index),
    .read_busy     (bus.read_busy),
    .write_enable  (bus.write_enable),
    .write_index   (bus.write_index),
    .reserve_valid (bus.reserve_valid),
    .reserve_index (bus.reserve_index),
    .reserve_ready (bus.reserve_ready)
  );

endmodule

// File: tb/tb_banked_register_file.sv
// Bench for banked_register_file: a default instance (32 regs, 4 long,
// 16/24 bits, 2 read ports) and a narrow instance (16 regs, no long,
// 16 bits, 3 read ports). Directed stimulus pushes expected values into a
// queue; a monitor pops and compares them on the falling clock edge.
module tb_banked_register_file;

  typedef enum int {K_DATA, K_BUSY, K_READY} kind_e;

  typedef struct {
    string       name;
    int          dut;   // 0 = default instance, 1 = narrow instance
    kind_e       kind;
    int          port;
    logic [23:0] value;
  } exp_t;

  logic clk;
  logic rst_n;

  banked_register_file_if #(.NUM_REGS(32), .LONG_W(24), .NUM_READ(2)) bus_a ();
  banked_register_file_if #(.NUM_REGS(16), .LONG_W(16), .NUM_READ(3)) bus_b ();

  banked_register_file dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  banked_register_file #(
    .NUM_REGS (16),
    .NUM_LONG (0),
    .SHORT_W  (16),
    .LONG_W   (16),
    .NUM_READ (3)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [23:0] actual(input exp_t e);
    logic [23:0] v;
    v = '0;
    if (e.dut == 0) begin
      case (e.kind)
        K_DATA:  v = bus_a.read_data[e.port*24 +: 24];
        K_BUSY:  v = 24'(bus_a.read_busy[e.port]);
        default: v = 24'(bus_a.reserve_ready);
      endcase
    end else begin
      case (e.kind)
        K_DATA:  v = 24'(bus_b.read_data[e.port*16 +: 16]);
        K_BUSY:  v = 24'(bus_b.read_busy[e.port]);
        default: v = 24'(bus_b.reserve_ready);
      endcase
    end
    return v;
  endfunction

  // Monitor: outputs are stable mid-cycle; compare everything queued.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_checks++;
      if (actual(cur) !== cur.value) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", cur.name, actual(cur), cur.value);
      end
    end
  end

  task automatic push_exp(input string name, input int dut, input kind_e kind,
                          input int port, input logic [23:0] value);
    exp_t e;
    e.name  = name;
    e.dut   = dut;
    e.kind  = kind;
    e.port  = port;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_a(input int p, input int idx);
    bus_a.read_index[p*5 +: 5] = 5'(idx);
  endtask

  task automatic rd_b(input int p, input int idx);
    bus_b.read_index[p*4 +: 4] = 4'(idx);
  endtask

  task automatic wr_a(input logic en, input int idx, input logic [23:0] data);
    bus_a.write_enable = en;
    bus_a.write_index  = 5'(idx);
    bus_a.write_data   = data;
  endtask

  task automatic rsv_a(input logic valid, input int idx);
    bus_a.reserve_valid = valid;
    bus_a.reserve_index = 5'(idx);
  endtask

  task automatic wr_b(input logic en, input int idx, input logic [15:0] data);
    bus_b.write_enable = en;
    bus_b.write_index  = 4'(idx);
    bus_b.write_data   = data;
  endtask

  task automatic rsv_b(input logic valid, input int idx);
    bus_b.reserve_valid = valid;
    bus_b.reserve_index = 4'(idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus_a.read_index = '0;
    bus_b.read_index = '0;
    wr_a(1'b0, 0, 24'h0);
    rsv_a(1'b0, 0);
    wr_b(1'b0, 0, 16'h0);
    rsv_b(1'b0, 0);

    // Held in reset: everything reads 0, reserve_ready follows reserve_valid.
    step();
    rd_a(0, 3); rd_a(1, 31); rsv_a(1'b1, 9);
    rd_b(0, 15); rd_b(1, 0); rd_b(2, 7);
    push_exp("reset_a_data_3", 0, K_DATA, 0, 24'h0);
    push_exp("reset_a_data_31", 0, K_DATA, 1, 24'h0);
    push_exp("reset_a_busy0", 0, K_BUSY, 0, 24'h0);
    push_exp("reset_a_busy1", 0, K_BUSY, 1, 24'h0);
    push_exp("reset_a_ready", 0, K_READY, 0, 24'h1);
    push_exp("reset_b_data0", 1, K_DATA, 0, 24'h0);
    push_exp("reset_b_busy2", 1, K_BUSY, 2, 24'h0);
    push_exp("reset_b_ready", 1, K_READY, 0, 24'h0);

    // Release; write 0xABCDEF to short register 5, bypass shows it masked.
    step();
    rst_n = 1'b1;
    rsv_a(1'b0, 0);
    wr_a(1'b1, 5, 24'hABCDEF); rd_a(0, 5); rd_a(1, 31);
    push_exp("bypass_short_5", 0, K_DATA, 0, 24'h00CDEF);
    push_exp("after_reset_31", 0, K_DATA, 1, 24'h0);

    // Storage of 5; write 0xABCDEF to long register 30 with bypass.
    step();
    wr_a(1'b1, 30, 24'hABCDEF); rd_a(0, 5); rd_a(1, 30);
    push_exp("stored_short_5", 0, K_DATA, 0, 24'h00CDEF);
    push_exp("bypass_long_30", 0, K_DATA, 1, 24'hABCDEF);

    // Storage of 30; index 0 is ordinary; reserve 29.
    step();
    wr_a(1'b0, 0, 24'h0); rd_a(0, 0); rd_a(1, 30); rsv_a(1'b1, 29);
    push_exp("stored_long_30", 0, K_DATA, 1, 24'hABCDEF);
    push_exp("index0_zero", 0, K_DATA, 0, 24'h0);
    push_exp("reserve_29_ready", 0, K_READY, 0, 24'h1);

    // 29 now busy.
    step();
    rsv_a(1'b0, 0); rd_a(1, 29);
    push_exp("busy_29", 0, K_BUSY, 1, 24'h1);

    // Commit 0x123456 to 29 with same-cycle read; reserve 7.
    step();
    wr_a(1'b1, 29, 24'h123456); rd_a(0, 7); rd_a(1, 29); rsv_a(1'b1, 7);
    push_exp("bypass_29_data", 0, K_DATA, 1, 24'h123456);
    push_exp("bypass_29_busy", 0, K_BUSY, 1, 24'h0);
    push_exp("reserve_7_ready", 0, K_READY, 0, 24'h1);
    push_exp("busy_7_before", 0, K_BUSY, 0, 24'h0);

    // 7 busy, 29 stored and free; re-reserve of 7 refused.
    step();
    wr_a(1'b0, 0, 24'h0); rsv_a(1'b1, 7);
    push_exp("busy_7_after", 0, K_BUSY, 0, 24'h1);
    push_exp("stored_29", 0, K_DATA, 1, 24'h123456);
    push_exp("cleared_29", 0, K_BUSY, 1, 24'h0);
    push_exp("rereserve_7_refused", 0, K_READY, 0, 24'h0);

    // Still refused, 7 still busy; write to non-busy short register 4.
    step();
    wr_a(1'b1, 4, 24'h000055); rd_a(1, 4);
    push_exp("refused_again_7", 0, K_READY, 0, 24'h0);
    push_exp("still_busy_7", 0, K_BUSY, 0, 24'h1);
    push_exp("bypass_4", 0, K_DATA, 1, 24'h000055);
    push_exp("nonbusy_4_busy", 0, K_BUSY, 1, 24'h0);

    // Write 7 with same-cycle re-reserve of 7.
    step();
    wr_a(1'b1, 7, 24'hFEDCBA); rsv_a(1'b1, 7);
    push_exp("wr_rsv_7_ready", 0, K_READY, 0, 24'h1);
    push_exp("wr_rsv_7_bypass", 0, K_DATA, 0, 24'h00DCBA);
    push_exp("wr_rsv_7_busy", 0, K_BUSY, 0, 24'h0);
    push_exp("stored_4", 0, K_DATA, 1, 24'h000055);
    push_exp("stored_4_busy", 0, K_BUSY, 1, 24'h0);

    // Set wins: 7 busy with new data; write long register 28; reserve 30.
    step();
    wr_a(1'b1, 28, 24'h89ABCD); rsv_a(1'b1, 30); rd_a(1, 28);
    push_exp("set_wins_7_busy", 0, K_BUSY, 0, 24'h1);
    push_exp("set_wins_7_data", 0, K_DATA, 0, 24'h00DCBA);
    push_exp("bypass_long_28", 0, K_DATA, 1, 24'h89ABCD);
    push_exp("reserve_30_ready", 0, K_READY, 0, 24'h1);

    // Long 28 stored in full; 30 busy.
    step();
    wr_a(1'b0, 0, 24'h0); rsv_a(1'b0, 0); rd_a(0, 28); rd_a(1, 30);
    push_exp("stored_long_28", 0, K_DATA, 0, 24'h89ABCD);
    push_exp("busy_30", 0, K_BUSY, 1, 24'h1);

    // Mid-cycle asynchronous reset during a write, with no clock edge.
    step();
    rd_a(0, 7); rd_a(1, 28); wr_a(1'b1, 5, 24'h111111); rsv_a(1'b1, 7);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_a.read_data[23:0] !== 24'h0) begin
      n_fail++;
      $display("FAIL imm_rst_data_p0: got 0x%0h, expected 0x0", bus_a.read_data[23:0]);
    end
    n_checks++;
    if (bus_a.read_data[47:24] !== 24'h0) begin
      n_fail++;
      $display("FAIL imm_rst_data_p1: got 0x%0h, expected 0x0", bus_a.read_data[47:24]);
    end
    n_checks++;
    if (bus_a.read_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL imm_rst_busy: got 0x%0h, expected 0x0", bus_a.read_busy);
    end
    n_checks++;
    if (bus_a.reserve_ready !== bus_a.reserve_valid) begin
      n_fail++;
      $display("FAIL imm_rst_ready: got %0b, expected %0b", bus_a.reserve_ready, bus_a.reserve_valid);
    end
    push_exp("async_rst_data7", 0, K_DATA, 0, 24'h0);
    push_exp("async_rst_busy7", 0, K_BUSY, 0, 24'h0);
    push_exp("async_rst_data28", 0, K_DATA, 1, 24'h0);
    push_exp("async_rst_ready", 0, K_READY, 0, 24'h1);

    // Released: nothing survived, including the in-flight write to 5.
    step();
    rst_n = 1'b1;
    wr_a(1'b0, 0, 24'h0); rsv_a(1'b0, 0); rd_a(0, 5); rd_a(1, 30);
    push_exp("post_rst_5", 0, K_DATA, 0, 24'h0);
    push_exp("post_rst_30", 0, K_DATA, 1, 24'h0);
    push_exp("post_rst_busy30", 0, K_BUSY, 1, 24'h0);

    step();
    rd_a(0, 31); rd_a(1, 7);
    push_exp("post_rst_31", 0, K_DATA, 0, 24'h0);
    push_exp("post_rst_busy7", 0, K_BUSY, 1, 24'h0);

    // Narrow instance: 0xFFFF to 15 on all three ports.
    step();
    wr_b(1'b1, 15, 16'hFFFF); rd_b(0, 15); rd_b(1, 15); rd_b(2, 15);
    push_exp("b_bypass_15_p0", 1, K_DATA, 0, 24'h00FFFF);
    push_exp("b_bypass_15_p1", 1, K_DATA, 1, 24'h00FFFF);
    push_exp("b_bypass_15_p2", 1, K_DATA, 2, 24'h00FFFF);

    step();
    wr_b(1'b0, 0, 16'h0); rsv_b(1'b1, 3); rd_b(2, 3);
    push_exp("b_stored_15_p0", 1, K_DATA, 0, 24'h00FFFF);
    push_exp("b_stored_15_p1", 1, K_DATA, 1, 24'h00FFFF);
    push_exp("b_reserve_3_ready", 1, K_READY, 0, 24'h1);
    push_exp("b_busy3_before", 1, K_BUSY, 2, 24'h0);

    step();
    rsv_b(1'b0, 0); wr_b(1'b1, 0, 16'hABCD); rd_b(0, 0);
    push_exp("b_busy3_after", 1, K_BUSY, 2, 24'h1);
    push_exp("b_bypass_0", 1, K_DATA, 0, 24'h00ABCD);

    step();
    wr_b(1'b0, 0, 16'h0);
    push_exp("b_stored_0", 1, K_DATA, 0, 24'h00ABCD);
    push_exp("b_stored_15_p1_again", 1, K_DATA, 1, 24'h00FFFF);

    // Let the monitor drain the last entries.
    step();
    step();
    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL check_count: only %0d checks evaluated, expected at least 12", n_checks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
